// File: rtl/uar_pkg.sv
// Shared types and defaults for the UART host-side controller.
package uar_pkg;

    localparam int BYTE_W     = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_GAP  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uar_host_ctrl_if.sv
// Host and UART byte-handshake signals of the host controller.
// slave = controller side, master = host/UART side.
interface uar_host_ctrl_if
    import uar_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              Enable;
    logic              HostTxValid;
    logic [BYTE_W-1:0] HostTxData;
    logic              HostTxReady;
    logic              HostRxValid;
    logic [BYTE_W-1:0] HostRxData;
    logic              HostRxReady;
    logic              UartTxEn;
    logic [BYTE_W-1:0] UartTxData;
    logic              UartTxDone;
    logic              UartRxEn;
    logic [BYTE_W-1:0] UartRxData;
    logic              UartRxDone;
    logic              RxOverrun;
    logic              RxOverrunClr;
    logic [ADDR_W:0]   TxLevel;
    logic [ADDR_W:0]   RxLevel;

    modport slave (
        input  Enable, HostTxValid, HostTxData, HostRxReady,
               UartTxDone, UartRxData, UartRxDone, RxOverrunClr,
        output HostTxReady, HostRxValid, HostRxData,
               UartTxEn, UartTxData, UartRxEn, RxOverrun, TxLevel, RxLevel
    );

    modport master (
        output Enable, HostTxValid, HostTxData, HostRxReady,
               UartTxDone, UartRxData, UartRxDone, RxOverrunClr,
        input  HostTxReady, HostRxValid, HostRxData,
               UartTxEn, UartTxData, UartRxEn, RxOverrun, TxLevel, RxLevel
    );

endinterface

// File: rtl/uar_sync_fifo.sv
// Synchronous FIFO with a registered head word. The head register is
// refreshed on push-into-empty and on every pop, so o_data always holds the
// oldest entry one cycle after it becomes the head.
module uar_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [WIDTH-1:0]  i_data,
    output logic [WIDTH-1:0]  o_data,
    output logic [ADDR_W:0]   o_level,
    output logic              o_full,
    output logic              o_empty
);

    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W+1)'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [WIDTH-1:0]  r_head;

    logic              w_pop_eff;
    logic              w_push_eff;
    logic [ADDR_W-1:0] w_rd_next;

    assign o_empty    = (r_level == '0);
    assign o_full     = (r_level == LVL_FULL);
    // A pop on an empty FIFO is ignored; a push at full is legal only with a pop.
    assign w_pop_eff  = i_pop & ~o_empty;
    assign w_push_eff = i_push & (~o_full | w_pop_eff);
    assign w_rd_next  = r_rd_ptr + ADDR_W'(1);

    assign o_data  = r_head;
    assign o_level = r_level;

    // Storage array, written at the tail on every accepted push.
    always_ff @(posedge i_clk) begin
        if (w_push_eff) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_eff) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop_eff)  r_rd_ptr <= w_rd_next;
            case ({w_push_eff, w_pop_eff})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Head register: take the incoming word when it becomes the head,
    // otherwise advance to the next stored entry on a pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
        end else if (w_push_eff && (o_empty || (w_pop_eff && r_level == LVL_ONE))) begin
            r_head <= i_data;
        end else if (w_pop_eff) begin
            r_head <= r_mem[w_rd_next];
        end
    end

endmodule

// File: rtl/uar_host_ctrl.sv
// Host-side controller for the UART byte handshake: TX FIFO feeding the
// UART transmitter one byte at a time, RX FIFO capturing received bytes
// with sticky overrun detection.
//
// TX FSM states
//   state   | meaning
//   TX_IDLE | waiting for Enable and a buffered byte; pops the head
//   TX_SEND | UartTxEn high, UartTxData held until UartTxDone
//   TX_GAP  | single re-arm cycle with UartTxEn low
module uar_host_ctrl
    import uar_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic            Clk,
    input  logic            Rst_n,
    uar_host_ctrl_if.slave  bus
);

    tx_state_t         r_state;
    logic              r_tx_en;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_tx_pend;
    logic              r_rx_en;
    logic              r_overrun;

    logic              w_tx_pop;
    logic [BYTE_W-1:0] w_tx_head;
    logic [ADDR_W:0]   w_tx_level;
    logic              w_tx_full;
    logic              w_tx_empty;

    logic              w_rx_push;
    logic              w_rx_drop;
    logic [ADDR_W:0]   w_rx_level;
    logic              w_rx_full;
    logic              w_rx_empty;

    // The FSM only pops from IDLE, using the registered non-empty flag, so
    // a byte pushed into an empty FIFO reaches the UART two edges later.
    assign w_tx_pop  = (r_state == TX_IDLE) & bus.Enable & r_tx_pend;

    assign w_rx_push = bus.UartRxDone & bus.Enable;
    // When full, a byte is kept only if the host frees a slot in the same cycle.
    assign w_rx_drop = w_rx_push & w_rx_full & ~bus.HostRxReady;

    uar_sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(BYTE_W)) u_tx_fifo (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_push  (bus.HostTxValid),
        .i_pop   (w_tx_pop),
        .i_data  (bus.HostTxData),
        .o_data  (w_tx_head),
        .o_level (w_tx_level),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    uar_sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(BYTE_W)) u_rx_fifo (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_push  (w_rx_push),
        .i_pop   (bus.HostRxReady),
        .i_data  (bus.UartRxData),
        .o_data  (bus.HostRxData),
        .o_level (w_rx_level),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    assign bus.HostTxReady = ~w_tx_full;
    assign bus.HostRxValid = ~w_rx_empty;
    assign bus.TxLevel     = w_tx_level;
    assign bus.RxLevel     = w_rx_level;
    assign bus.UartTxEn    = r_tx_en;
    assign bus.UartTxData  = r_tx_data;
    assign bus.UartRxEn    = r_rx_en;
    assign bus.RxOverrun   = r_overrun;

    // TX sequencer: IDLE -> SEND on pop, SEND -> GAP on UartTxDone, GAP -> IDLE.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= TX_IDLE;
            r_tx_en   <= 1'b0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_data <= w_tx_head;
                        r_tx_en   <= 1'b1;
                        r_state   <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (bus.UartTxDone) begin
                        r_tx_en <= 1'b0;
                        r_state <= TX_GAP;
                    end
                end
                TX_GAP: begin
                    r_state <= TX_IDLE;
                end
                default: begin
                    r_tx_en <= 1'b0;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    // Registered TX-pending flag and receiver enable.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_tx_pend <= 1'b0;
            r_rx_en   <= 1'b0;
        end else begin
            r_tx_pend <= ~w_tx_empty;
            r_rx_en   <= bus.Enable;
        end
    end

    // Sticky overrun flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_rx_drop) begin
            r_overrun <= 1'b1;
        end else if (bus.RxOverrunClr) begin
            r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uar_host_ctrl.sv
// Self-checking bench for uar_host_ctrl: directed steps with randomized data,
// hold times and RX traffic, checked against queue-based reference models.
module tb_uar_host_ctrl;
    import uar_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    always #5 Clk = ~Clk;

    uar_host_ctrl_if #(.ADDR_W(AW)) bus ();

    uar_host_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    bit         m_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_tx_en(input string tag, output int cyc);
        cyc = 0;
        while (bus.UartTxEn !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        if (cyc >= 200) check({tag, "_timeout"}, 32'(bus.UartTxEn), 32'd1);
    endtask

    // Byte currently in SEND: check it, hold it, complete it, check the gap cycle.
    task automatic serve_byte(input string tag, input int hold, input logic [7:0] exp);
        bit ok;
        check({tag, "_data"}, 32'(bus.UartTxData), 32'(exp));
        ok = 1'b1;
        for (int k = 0; k < hold; k++) begin
            step();
            if (bus.UartTxEn !== 1'b1 || bus.UartTxData !== exp) ok = 1'b0;
        end
        check({tag, "_hold"}, 32'(ok), 32'd1);
        bus.UartTxDone = 1'b1;
        step();
        bus.UartTxDone = 1'b0;
        check({tag, "_gap"}, 32'(bus.UartTxEn), 32'd0);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        bus.UartRxData = d;
        bus.UartRxDone = 1'b1;
        step();
        bus.UartRxDone = 1'b0;
        if (bus.Enable) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(d);
            else m_ov = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        logic [7:0] b;
        logic [7:0] b0;
        logic [7:0] b1;
        bit         ok;
        bit         pop;
        bit         was_full;
        bit         done;
        bit         clr;
        logic [7:0] d;

        bus.Enable       = 1'b0;
        bus.HostTxValid  = 1'b0;
        bus.HostTxData   = '0;
        bus.HostRxReady  = 1'b0;
        bus.UartTxDone   = 1'b0;
        bus.UartRxData   = '0;
        bus.UartRxDone   = 1'b0;
        bus.RxOverrunClr = 1'b0;
        m_ov             = 1'b0;

        // ---- reset state ----
        #22;
        check("rst_txlevel",  32'(bus.TxLevel),     32'd0);
        check("rst_rxlevel",  32'(bus.RxLevel),     32'd0);
        check("rst_txready",  32'(bus.HostTxReady), 32'd1);
        check("rst_rxvalid",  32'(bus.HostRxValid), 32'd0);
        check("rst_rxdata",   32'(bus.HostRxData),  32'd0);
        check("rst_txen",     32'(bus.UartTxEn),    32'd0);
        check("rst_txdata",   32'(bus.UartTxData),  32'd0);
        check("rst_rxen",     32'(bus.UartRxEn),    32'd0);
        check("rst_overrun",  32'(bus.RxOverrun),   32'd0);
        step();
        Rst_n = 1'b1;
        step();

        // ---- single byte ----
        bus.Enable = 1'b1;
        step();
        check("rxen_follows", 32'(bus.UartRxEn), 32'd1);
        bus.HostTxValid = 1'b1;
        bus.HostTxData  = 8'hA5;
        step();
        bus.HostTxValid = 1'b0;
        check("single_lvl1",  32'(bus.TxLevel),  32'd1);
        check("single_en_n0", 32'(bus.UartTxEn), 32'd0);
        step();
        check("single_en_n1", 32'(bus.UartTxEn), 32'd0);
        step();
        check("single_en_n2", 32'(bus.UartTxEn), 32'd1);
        check("single_lvl0",  32'(bus.TxLevel),  32'd0);
        serve_byte("single", 100, 8'hA5);
        step();
        check("single_idle_en", 32'(bus.UartTxEn), 32'd0);
        step();
        check("single_no_more", 32'(bus.UartTxEn), 32'd0);

        // ---- burst / full ----
        bus.Enable = 1'b0;
        step();
        ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.HostTxReady !== 1'b1) ok = 1'b0;
            bus.HostTxValid = 1'b1;
            bus.HostTxData  = 8'(i);
            step();
            tx_q.push_back(8'(i));
        end
        bus.HostTxValid = 1'b0;
        check("burst_ready_while_filling", 32'(ok), 32'd1);
        check("burst_full_ready", 32'(bus.HostTxReady), 32'd0);
        check("burst_full_level", 32'(bus.TxLevel),     32'd16);
        bus.HostTxValid = 1'b1;
        bus.HostTxData  = 8'hEE;
        step();
        bus.HostTxValid = 1'b0;
        check("burst_17th_level", 32'(bus.TxLevel),     32'd16);
        check("burst_17th_ready", 32'(bus.HostTxReady), 32'd0);
        repeat (3) step();
        check("burst_disabled_no_tx", 32'(bus.UartTxEn), 32'd0);
        bus.Enable = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wait_tx_en("burst_wait", cyc);
            check("burst_spacing", 32'(cyc), (i == 0) ? 32'd1 : 32'd2);
            serve_byte("burst", int'($urandom_range(0, 6)), tx_q.pop_front());
        end
        check("burst_drained", 32'(bus.TxLevel), 32'd0);

        // ---- RX overrun ----
        for (int v = 8'h10; v <= 8'h20; v++) begin
            rx_pulse(8'(v));
            repeat ($urandom_range(0, 2)) step();
        end
        check("ovr_level", 32'(bus.RxLevel),   32'(rx_q.size()));
        check("ovr_flag",  32'(bus.RxOverrun), 32'(m_ov));
        check("ovr_full",  32'(bus.RxLevel),   32'd16);
        for (int v = 8'h10; v <= 8'h1F; v++) begin
            check("ovr_read_valid", 32'(bus.HostRxValid), 32'd1);
            check("ovr_read_data",  32'(bus.HostRxData),  32'(rx_q[0]));
            check("ovr_read_order", 32'(bus.HostRxData),  32'(v));
            bus.HostRxReady = 1'b1;
            step();
            bus.HostRxReady = 1'b0;
            void'(rx_q.pop_front());
        end
        check("ovr_empty_valid", 32'(bus.HostRxValid), 32'd0);
        check("ovr_empty_level", 32'(bus.RxLevel),     32'd0);
        check("ovr_still_set",   32'(bus.RxOverrun),   32'd1);
        bus.RxOverrunClr = 1'b1;
        step();
        bus.RxOverrunClr = 1'b0;
        m_ov = 1'b0;
        check("ovr_cleared", 32'(bus.RxOverrun), 32'd0);

        // ---- simultaneous push/pop at full ----
        for (int i = 0; i < DEPTH; i++) rx_pulse(8'($urandom));
        check("sim_full", 32'(bus.RxLevel), 32'd16);
        bus.UartRxData  = 8'h55;
        bus.UartRxDone  = 1'b1;
        bus.HostRxReady = 1'b1;
        step();
        bus.UartRxDone  = 1'b0;
        bus.HostRxReady = 1'b0;
        void'(rx_q.pop_front());
        rx_q.push_back(8'h55);
        check("sim_level",   32'(bus.RxLevel),    32'd16);
        check("sim_overrun", 32'(bus.RxOverrun),  32'd0);
        check("sim_head",    32'(bus.HostRxData), 32'(rx_q[0]));
        // drop and clear in the same cycle: set wins
        bus.RxOverrunClr = 1'b1;
        rx_pulse(8'h99);
        bus.RxOverrunClr = 1'b0;
        check("set_wins", 32'(bus.RxOverrun), 32'(m_ov));

        // ---- random RX traffic against the queue model ----
        for (int t = 0; t < 300; t++) begin
            if (bus.RxLevel !== 5'(rx_q.size()) || bus.RxOverrun !== m_ov ||
                bus.HostRxValid !== (rx_q.size() != 0) ||
                (rx_q.size() != 0 && bus.HostRxData !== rx_q[0])) begin
                check("rand_rx_level",   32'(bus.RxLevel),     32'(rx_q.size()));
                check("rand_rx_overrun", 32'(bus.RxOverrun),   32'(m_ov));
                check("rand_rx_valid",   32'(bus.HostRxValid), 32'(rx_q.size() != 0));
            end else begin
                check("rand_rx_state", 32'(bus.RxLevel), 32'(rx_q.size()));
            end
            done = ($urandom_range(0, 1) == 0);
            d    = 8'($urandom);
            pop  = ($urandom_range(0, 2) == 0);
            clr  = ($urandom_range(0, 15) == 0);
            bus.UartRxDone   = done;
            bus.UartRxData   = d;
            bus.HostRxReady  = pop;
            bus.RxOverrunClr = clr;
            was_full = (rx_q.size() == DEPTH);
            pop      = pop && (rx_q.size() != 0);
            if (pop) void'(rx_q.pop_front());
            if (done && was_full && !pop) m_ov = 1'b1;
            else if (clr) m_ov = 1'b0;
            if (done && (!was_full || pop)) rx_q.push_back(d);
            step();
        end
        bus.UartRxDone   = 1'b0;
        bus.RxOverrunClr = 1'b0;
        bus.HostRxReady  = 1'b0;
        check("rand_end_level",   32'(bus.RxLevel),   32'(rx_q.size()));
        check("rand_end_overrun", 32'(bus.RxOverrun), 32'(m_ov));
        ok = 1'b1;
        while (rx_q.size() != 0) begin
            if (bus.HostRxValid !== 1'b1 || bus.HostRxData !== rx_q[0]) ok = 1'b0;
            bus.HostRxReady = 1'b1;
            step();
            void'(rx_q.pop_front());
        end
        bus.HostRxReady = 1'b0;
        check("rand_drain_data",  32'(ok),              32'd1);
        check("rand_drain_empty", 32'(bus.HostRxValid), 32'd0);

        // ---- Enable drop mid-byte ----
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        bus.HostTxValid = 1'b1;
        bus.HostTxData  = b0;
        step();
        bus.HostTxData  = b1;
        step();
        bus.HostTxValid = 1'b0;
        tx_q.push_back(b0);
        tx_q.push_back(b1);
        wait_tx_en("drop_wait", cyc);
        bus.Enable = 1'b0;
        step();
        check("drop_rxen",  32'(bus.UartRxEn), 32'd0);
        check("drop_txen",  32'(bus.UartTxEn), 32'd1);
        rx_pulse(8'h77);
        check("drop_rx_ignored", 32'(bus.RxLevel), 32'(rx_q.size()));
        serve_byte("drop_b0", 3, tx_q.pop_front());
        ok = 1'b1;
        repeat (8) begin
            step();
            if (bus.UartTxEn !== 1'b0) ok = 1'b0;
        end
        check("drop_no_next_pop", 32'(ok),          32'd1);
        check("drop_level",       32'(bus.TxLevel), 32'd1);
        bus.Enable = 1'b1;
        wait_tx_en("drop_resume", cyc);
        serve_byte("drop_b1", int'($urandom_range(1, 4)), tx_q.pop_front());

        // ---- async reset in SEND ----
        for (int i = 0; i <= DEPTH; i++) rx_pulse(8'($urandom));
        check("ar_overrun_set", 32'(bus.RxOverrun), 32'd1);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            bus.HostTxValid = 1'b1;
            bus.HostTxData  = b;
            step();
        end
        bus.HostTxValid = 1'b0;
        check("ar_in_send",  32'(bus.UartTxEn), 32'd1);
        check("ar_level5",   32'(bus.TxLevel),  32'd5);
        #3;
        Rst_n = 1'b0;
        #1;
        check("ar_txen",    32'(bus.UartTxEn),    32'd0);
        check("ar_txlevel", 32'(bus.TxLevel),     32'd0);
        check("ar_overrun", 32'(bus.RxOverrun),   32'd0);
        check("ar_rxlevel", 32'(bus.RxLevel),     32'd0);
        check("ar_txready", 32'(bus.HostTxReady), 32'd1);
        tx_q.delete();
        rx_q.delete();
        m_ov = 1'b0;
        step();
        Rst_n = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            step();
            if (bus.UartTxEn !== 1'b0 || bus.TxLevel !== '0) ok = 1'b0;
        end
        check("ar_quiet_after_release", 32'(ok), 32'd1);
        b = 8'($urandom);
        bus.HostTxValid = 1'b1;
        bus.HostTxData  = b;
        step();
        bus.HostTxValid = 1'b0;
        step();
        check("ar_new_n1", 32'(bus.UartTxEn), 32'd0);
        step();
        check("ar_new_n2", 32'(bus.UartTxEn), 32'd1);
        serve_byte("ar_new", 2, b);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uar_host_ctrl.md
Name: uar_host_ctrl

Overview:
- Host-side controller at the other end of the UART core's byte handshake (TxEn/TxData/TxDone, RxEn/RxData/RxDone).
- Buffers host bytes in a TX FIFO and sequences them one at a time into the UART transmitter.
- Captures every RxDone byte from the UART receiver into an RX FIFO for the host, with overrun detection.
- Sits between the AXI/register front end and the UART core; no baud logic inside.

Parameters:
- DEPTH, 16, entries per FIFO; power of two, 2..256.
- ADDR_W, 4, log2(DEPTH).

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- Enable  in  1  global enable for TX sequencing and RX capture
- HostTxValid  in  1  host offers a TX byte
- HostTxData  in  8  TX byte
- HostTxReady  out  1  TX FIFO not full
- HostRxValid  out  1  RX FIFO not empty
- HostRxData  out  8  RX FIFO head byte, valid when HostRxValid
- HostRxReady  in  1  host consumes the head byte
- UartTxEn  out  1  to UART TxEn
- UartTxData  out  8  to UART TxData
- UartTxDone  in  1  one-cycle pulse: byte sent
- UartRxEn  out  1  to UART RxEn
- UartRxData  in  8  from UART RxData
- UartRxDone  in  1  one-cycle pulse: UartRxData valid
- RxOverrun  out  1  sticky: a received byte was dropped
- RxOverrunClr  in  1  clears RxOverrun
- TxLevel  out  ADDR_W+1  TX FIFO occupancy
- RxLevel  out  ADDR_W+1  RX FIFO occupancy

Behaviour:
- Reset (async assert, sync release): both FIFOs empty, TxLevel=RxLevel=0, HostTxReady=1, HostRxValid=0, HostRxData=0, UartTxEn=0, UartTxData=0, UartRxEn=0, RxOverrun=0, TX FSM in IDLE.
- Reset mid-byte: UartTxEn drops immediately and FIFO contents are discarded. A partially sent byte is not resent.
- FIFOs:
  - Push on Valid&Ready; pop on head consumed.
  - Pointers wrap modulo DEPTH; level is held in ADDR_W+1 bits so full equals level==DEPTH.
  - Simultaneous push and pop: level unchanged, legal at full and at empty. At empty, a same-cycle pop is ignored and only the push takes effect.
  - Head data is registered and appears one cycle after the push into an empty FIFO.
- TX FSM (IDLE, SEND, GAP):
  - IDLE: if Enable and TxLevel!=0, pop the head into UartTxData, set UartTxEn=1, go to SEND. A byte pushed into an empty FIFO at edge N gives UartTxEn=1 after edge N+2.
  - SEND: hold UartTxEn=1 and UartTxData stable until UartTxDone, then UartTxEn=0 and go to GAP. Enable dropping in SEND does not abort the byte.
  - GAP: exactly one cycle with UartTxEn=0 (the UART re-arm gap), then go to IDLE.
  - UartTxDone outside SEND is ignored.
  - Back-to-back throughput is one byte per (UART byte time + 2 cycles).
- RX:
  - UartRxEn = registered Enable.
  - On UartRxDone while Enable: push UartRxData if RxLevel<DEPTH, or if the host pops in the same cycle. Otherwise drop the byte and set RxOverrun.
  - RxOverrunClr clears RxOverrun; set wins if both occur in the same cycle.
  - UartRxDone with Enable=0 is ignored.
- HostTxValid while HostTxReady=0: the byte is not accepted and the host must hold it. No data is lost.

Decomposition:
- Package uar_pkg: BYTE_W=8, TX state encoding (IDLE=2'd0, SEND=2'd1, GAP=2'd2), default DEPTH/ADDR_W.
- One sub-module uar_sync_fifo (DEPTH, ADDR_W, WIDTH=8), instantiated twice. It provides push/pop, data_in/data_out, level, full, empty.
- TX FSM and overrun logic live in the top.

Test Plan:
- Single byte: push 8'hA5 with Enable=1 -> UartTxEn rises 2 cycles later with UartTxData=8'hA5. Model UartTxDone after 100 cycles -> UartTxEn=0 for exactly 1 cycle; TxLevel returns to 0.
- Burst/full: Enable=0, push 16 bytes 8'h00..8'h0F -> HostTxReady=0 and TxLevel=16, 17th byte not accepted. Set Enable=1 -> bytes leave in order 00..0F, with UartTxData stable through each SEND.
- RX overrun: 17 UartRxDone pulses carrying 8'h10..8'h20 with no host read -> RxLevel=16 and RxOverrun=1, 8'h20 dropped. Read all -> order 10..1F. RxOverrunClr -> RxOverrun=0.
- Simultaneous: RX FIFO full, UartRxDone with 8'h55 and HostRxReady in the same cycle -> byte accepted, RxLevel stays 16, RxOverrun stays 0.
- Enable drop mid-byte: deassert Enable in SEND -> UartTxEn held until UartTxDone, no next pop, UartRxEn=0 one cycle after the Enable drop.
- Async reset in SEND with TxLevel=5 -> UartTxEn=0 without waiting for a clock edge, TxLevel=0, RxOverrun=0; after release there is no TX activity until a new push.
